// File: rtl/pgen_bars.sv
// Test-pattern source for the hub75 frame-buffer write port: renders one of four
// patterns row by row, stores/swaps each row, then swaps the frame.
module pgen_bars #(
    parameter int N_BANKS  = 2,
    parameter int N_ROWS   = 32,
    parameter int N_COLS   = 64,
    parameter int N_PLANES = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         en,
    input  logic [1:0]                                   mode,
    output logic [$clog2(N_BANKS)+$clog2(N_ROWS)-1:0]    fbw_row_addr,
    output logic                                         fbw_row_store,
    input  logic                                         fbw_row_rdy,
    output logic                                         fbw_row_swap,
    output logic [3*N_PLANES-1:0]                        fbw_data,
    output logic [$clog2(N_COLS)-1:0]                    fbw_col_addr,
    output logic                                         fbw_wren,
    output logic                                         frame_swap,
    input  logic                                         frame_rdy,
    output logic [N_PLANES-1:0]                          frame_cnt
);

    localparam int LOG_N_COLS = $clog2(N_COLS);
    localparam int RW         = $clog2(N_BANKS) + $clog2(N_ROWS);
    localparam int N_LINES    = N_BANKS * N_ROWS;
    localparam int SH_C       = N_PLANES - LOG_N_COLS;
    localparam int SH_R       = N_PLANES - RW;

    typedef enum logic [2:0] {IDLE, FILL, WAIT_RDY, STORE, FSWAP} state_t;

    state_t                  state;
    logic [LOG_N_COLS-1:0]   col;
    logic [1:0]              mode_q;
    logic [N_PLANES-1:0]     pr, pg, pb, v;
    logic [2:0]              bar;

    // Pixel colour for the current (col, row, frame); registered into fbw_data in FILL.
    always_comb begin
        bar = col[LOG_N_COLS-1 -: 3];
        v   = N_PLANES'(col) + N_PLANES'(fbw_row_addr) + frame_cnt;
        pr  = '1;
        pg  = '1;
        pb  = '1;
        case (mode_q)
            2'd1: begin
                pr = {N_PLANES{bar[0]}};
                pg = {N_PLANES{bar[1]}};
                pb = {N_PLANES{bar[2]}};
            end
            2'd2: begin
                pr = N_PLANES'(col) << SH_C;
                pg = N_PLANES'(fbw_row_addr) << SH_R;
                pb = frame_cnt;
            end
            2'd3: begin
                pr = v;
                pg = ~v;
                pb = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            col           <= '0;
            mode_q        <= '0;
            fbw_row_addr  <= '0;
            fbw_row_store <= 1'b0;
            fbw_row_swap  <= 1'b0;
            fbw_data      <= '0;
            fbw_col_addr  <= '0;
            fbw_wren      <= 1'b0;
            frame_swap    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            fbw_wren      <= 1'b0;
            fbw_row_store <= 1'b0;
            fbw_row_swap  <= 1'b0;
            frame_swap    <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && frame_rdy) begin
                        state        <= FILL;
                        mode_q       <= mode;
                        fbw_row_addr <= '0;
                        col          <= '0;
                    end
                end
                FILL: begin
                    fbw_wren     <= 1'b1;
                    fbw_col_addr <= col;
                    fbw_data     <= {pb, pg, pr};
                    col          <= col + 1'b1;
                    // The last pixel's wren cycle overlaps the first WAIT_RDY cycle.
                    if (col == LOG_N_COLS'(N_COLS - 1))
                        state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (fbw_row_rdy) begin
                        state         <= STORE;
                        fbw_row_store <= 1'b1;
                        fbw_row_swap  <= 1'b1;
                    end
                end
                STORE: begin
                    if (fbw_row_addr == RW'(N_LINES - 1)) begin
                        state      <= FSWAP;
                        frame_swap <= 1'b1;
                        frame_cnt  <= frame_cnt + 1'b1;
                    end else begin
                        state        <= FILL;
                        fbw_row_addr <= fbw_row_addr + 1'b1;
                        col          <= '0;
                    end
                end
                FSWAP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
